// File: rtl/csel_add_pkg.sv
// Shared types and helpers for the nibble-serial carry-select adder.
package csel_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int width);
    int nib;
    nib = width / NIBBLE_W;
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/fa4bit.sv
// 4-bit carry-select adder slice with scalar bit ports.
module fa4bit (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic cin,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic cout
);

  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [4:0] w_r0;
  logic [4:0] w_r1;

  assign w_a = {a3, a2, a1, a0};
  assign w_b = {b3, b2, b1, b0};

  // Both carry-in outcomes precomputed; cin only steers the final mux.
  assign w_r0 = {1'b0, w_a} + {1'b0, w_b};
  assign w_r1 = {1'b0, w_a} + {1'b0, w_b} + 5'd1;

  assign {cout, s3, s2, s1, s0} = cin ? w_r1 : w_r0;

endmodule

// File: rtl/csel_add_seq.sv
// Nibble-serial adder: one shared carry-select slice, LSB nibble first.
module csel_add_seq
  import csel_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0] w_a_nib;
  logic [3:0] w_b_nib;
  logic [3:0] w_s;
  logic       w_co;

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  fa4bit u_slice (
    .a0   (w_a_nib[0]),
    .a1   (w_a_nib[1]),
    .a2   (w_a_nib[2]),
    .a3   (w_a_nib[3]),
    .b0   (w_b_nib[0]),
    .b1   (w_b_nib[1]),
    .b2   (w_b_nib[2]),
    .b3   (w_b_nib[3]),
    .cin  (r_carry),
    .s0   (w_s[0]),
    .s1   (w_s[1]),
    .s2   (w_s[2]),
    .s3   (w_s[3]),
    .cout (w_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (r_idx == IW'(i)) begin
              r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_s;
            end
          end
          r_carry <= w_co;
          // Index parks on the top nibble instead of wrapping.
          if (r_idx == LAST) begin
            r_state <= DONE;
            r_cout  <= w_co;
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                       (w_s[3] != r_a[WIDTH-1]);
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
